// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, byte/strobe/status out.
// With UART_RX_PARITY_EN defined the bundle also carries parity_err.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (input rx, output data, valid, frame_err, busy, parity_err);
    modport slave  (output rx, input data, valid, frame_err, busy, parity_err);
`else
    modport master (input rx, output data, valid, frame_err, busy);
    modport slave  (output rx, input data, valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling via per-bit counter.
// Optional even-parity bit (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    uart_rx_if.master   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t     state_q;
    logic       rx_meta_q, rx_s_q;
    cnt_t       clk_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, data_q;
    logic       valid_q, ferr_q;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q, perr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= S_START;
                        clk_cnt_q <= '0;
                    end
                end
                // Re-check the line at the start-bit centre to reject glitches.
                S_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + cnt_t'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_cnt_q] <= rx_s_q;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + cnt_t'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        par_bad_q <= (^shift_q) ^ rx_s_q;
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + cnt_t'(1);
                    end
                end
`endif
                // Decide at the stop-bit centre; the remaining half stop bit is left to IDLE.
                S_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                        perr_q    <= par_bad_q;
                        if (rx_s_q) begin
                            if (!par_bad_q) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
`else
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
`endif
                    end else begin
                        clk_cnt_q <= clk_cnt_q + cnt_t'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame driver pushes expected events, monitor pops on each pulse.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;
    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int LAT = 2 + H + NB * C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus ();
    uart_rx #(.CLKS_PER_BIT(C)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    logic perr_sig;
`ifdef UART_RX_PARITY_EN
    assign perr_sig = bus.parity_err;
`else
    assign perr_sig = 1'b0;
`endif

    typedef struct {
        bit         ev;
        bit         ef;
        bit         ep;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    exp_t e;
    int   d;
    always @(negedge clk) begin
        if (rst_n && (bus.valid || bus.frame_err || perr_sig)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: valid=%0b ferr=%0b perr=%0b at cycle %0d",
                         bus.valid, bus.frame_err, perr_sig, cyc);
            end else begin
                e = sb.pop_front();
                check("valid", 32'(bus.valid), 32'(e.ev));
                check("frame_err", 32'(bus.frame_err), 32'(e.ef));
                check("parity_err", 32'(perr_sig), 32'(e.ep));
                check("data", 32'(bus.data), 32'(e.data));
                d = cyc - e.due;
                vectors++;
                if (d > 1 || d < -1) begin
                    miscompares++;
                    $display("FAIL latency: pulse at cycle %0d expected %0d +-1", cyc, e.due);
                end
            end
        end
    end

    task automatic bitp(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a frame produces exactly one event, decided by stop bit and parity.
    task automatic frame(input logic [7:0] dat, input logic par, input logic stop_v, input int stop_n);
        exp_t x;
        logic pe;
`ifdef UART_RX_PARITY_EN
        pe = (^dat) ^ par;
`else
        pe = 1'b0;
`endif
        x.ev  = stop_v && !pe;
        x.ef  = !stop_v;
        x.ep  = pe;
        x.due = cyc + LAT;
        if (x.ev) last_good = dat;
        x.data = last_good;
        sb.push_back(x);
        bitp(1'b0, C);
        for (int i = 0; i < 8; i++) bitp(dat[i], C);
`ifdef UART_RX_PARITY_EN
        bitp(par, C);
`endif
        bitp(stop_v, stop_n);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d events still pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int bc;
        logic [7:0] rd;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(bus.data), 32'h00);
        check("reset_valid", 32'(bus.valid), 0);
        check("reset_ferr", 32'(bus.frame_err), 0);
        check("reset_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        bitp(1'b1, 5);

        frame(8'hA5, ^8'hA5, 1'b1, C);
        bitp(1'b1, 4);
        drain();

        frame(8'h00, 1'b0, 1'b1, C);
        frame(8'hFF, 1'b0, 1'b1, C);
        bitp(1'b1, 10);
        drain();

        // Short low glitch: BUSY briefly, no pulse.
        bitp(1'b0, 5);
        bus.rx = 1'b1;
        bc = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (bus.busy) bc++;
        end
        vectors++;
        if (bc < 1 || bc > H + 2) begin
            miscompares++;
            $display("FAIL glitch_busy: busy for %0d cycles expected 1..%0d", bc, H + 2);
        end
        check("glitch_idle", 32'(bus.busy), 0);
        @(posedge clk);
        #1;

        // Stop bit low then line held low: one FRAME_ERR, stays busy until RX rises.
        frame(8'h3C, ^8'h3C, 1'b0, C);
        bitp(1'b0, 100);
        check("break_busy", 32'(bus.busy), 1);
        check("break_data", 32'(bus.data), 32'hFF);
        bitp(1'b1, 4);
        check("break_idle", 32'(bus.busy), 0);
        drain();

        // Reset during bit 4 of 8'h5A.
        rd = 8'h5A;
        bitp(1'b0, C);
        for (int i = 0; i < 4; i++) bitp(rd[i], C);
        bitp(rd[4], H);
        rst_n = 1'b0;
        bus.rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        last_good = 8'h00;
        bitp(1'b1, 10);
        check("midreset_data", 32'(bus.data), 32'h00);
        frame(8'hC3, ^8'hC3, 1'b1, C);
        bitp(1'b1, 4);
        drain();

`ifdef UART_RX_PARITY_EN
        frame(8'h07, 1'b1, 1'b1, C);
        frame(8'h07, 1'b0, 1'b1, C);
        bitp(1'b1, 4);
        drain();
`endif

        // Random traffic: mostly good frames with random gaps, some framing/parity errors.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] rb;
            logic rp;
            rb = 8'($urandom);
            rp = (^rb) ^ ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) != 0) begin
                frame(rb, rp, 1'b1, C + $urandom_range(0, 12));
            end else begin
                frame(rb, rp, 1'b0, C + $urandom_range(0, 30));
                bitp(1'b1, $urandom_range(2, 10));
            end
        end
        bitp(1'b1, 4);
        drain();
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
